// File: rtl/mfe_pkg.sv
// Shared constants, FSM states and window tap indices for the median filter front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mfe_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int CW    = 7;   // row/column counter width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Row-major tap positions inside the 3x3 window; P0 is (r-1,c-1).
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;
  localparam int CENTER = 4;

  // LSB of tap idx in the flattened window; P0 sits in the top byte.
  function automatic int tap_lsb(input int idx);
    return (8 - idx) * DW;
  endfunction

endpackage

// File: rtl/mfe_window_fetch_if.sv
// ROM read port plus window valid/ready channel of the window fetcher.
// Latency: n/a (wiring only).
// Backpressure: win_ready from the consumer holds the window in place.
interface mfe_window_fetch_if;
  import mfe_pkg::*;

  logic [AW-1:0]   iaddr;
  logic [DW-1:0]   idata;
  logic            win_valid;
  logic            win_ready;
  logic [9*DW-1:0] win_data;
  logic [CW-1:0]   win_row;
  logic [CW-1:0]   win_col;

  modport master (
    output iaddr,
    input  idata,
    output win_valid,
    input  win_ready,
    output win_data,
    output win_row,
    output win_col
  );

  modport slave (
    input  iaddr,
    output idata,
    input  win_valid,
    output win_ready,
    input  win_data,
    input  win_row,
    input  win_col
  );
endinterface

// File: rtl/mfe_win_shift.sv
// 3x3 pixel window register: clear, shift-left, and per-row loads of the middle/right column.
// Latency: every operation lands on the next clock edge.
// Backpressure: none; contents hold whenever no operation is requested.
module mfe_win_shift
  import mfe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            shl,
  input  logic            ld_vld,
  input  logic            ld_col2,   // 1: right column, 0: middle column
  input  logic            ld_dup,    // also copy a middle-column load into the left column
  input  logic [1:0]      ld_row,
  input  logic [DW-1:0]   ld_dat,
  output logic [9*DW-1:0] win_data
);

  logic [DW-1:0] win_q [0:8];
  logic [DW-1:0] win_d [0:8];
  logic [3:0]    base;

  assign base = {2'b00, ld_row} * 4'd3;

  // Next window contents: clear beats shift beats a single-pixel load.
  always_comb begin
    for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
    if (clr) begin
      for (int i = 0; i < 9; i++) win_d[i] = '0;
    end else if (shl) begin
      // Right column keeps its stale value; the next three loads overwrite it.
      win_d[P0] = win_q[P1];
      win_d[P1] = win_q[P2];
      win_d[P3] = win_q[P4];
      win_d[P4] = win_q[P5];
      win_d[P6] = win_q[P7];
      win_d[P7] = win_q[P8];
    end else if (ld_vld) begin
      if (ld_col2) begin
        win_d[base + 4'd2] = ld_dat;
      end else begin
        win_d[base + 4'd1] = ld_dat;
        if (ld_dup) win_d[base] = ld_dat;
      end
    end
  end

  // Window register bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_flat
    assign win_data[tap_lsb(g) +: DW] = win_q[g];
  end

endmodule

// File: rtl/mfe_window_fetch.sv
// Builds one 3x3 neighbourhood per pixel in raster order from the image ROM; MFE_WF_REPLICATE_EN selects border replication instead of zero padding.
// Latency: window valid 7 cycles after fetch start at column 0, 4 cycles otherwise; one idle cycle after every accept.
// Backpressure: window, coordinates and iaddr hold while win_valid && !win_ready.
module mfe_window_fetch
  import mfe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic busy,
  output logic done,
  mfe_window_fetch_if.master wf
);

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [2:0]    slot_q, slot_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic          cap_vld_q, cap_vld_d, cap_zero_q, cap_zero_d;
  logic          cap_col2_q, cap_col2_d, cap_dup_q, cap_dup_d;
  logic [1:0]    cap_row_q, cap_row_d;

  logic          first_col, fetching, win_hs, frame_end;
  logic          slot_col2, slot_zero, slot_dup, last_slot;
  logic [1:0]    slot_row;
  logic [7:0]    nr, nc;
  logic [CW-1:0] ar, ac;
  logic [AW-1:0] slot_addr;
  logic          win_clr, win_shl;
  logic [DW-1:0] ld_dat;

  assign first_col = (col_q == '0);
  assign fetching  = (state_q == FETCH);
  assign win_hs    = (state_q == OUT) && wf.win_ready;
  assign frame_end = (row_q == CW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

  // Decode the current read slot into neighbour coordinates and a ROM address.
  always_comb begin
    slot_col2 = !first_col || (slot_q >= 3'd3);
    slot_row  = (first_col && (slot_q >= 3'd3)) ? 2'(slot_q - 3'd3) : slot_q[1:0];
    last_slot = first_col ? (slot_q == 3'd5) : (slot_q == 3'd2);
    // 8-bit wrap: row -1 reads as 8'hFF, so one unsigned compare catches both edges.
    nr = {1'b0, row_q} + {6'b0, slot_row} - 8'd1;
    nc = {1'b0, col_q} + {7'b0, slot_col2};
`ifdef MFE_WF_REPLICATE_EN
    slot_zero = 1'b0;
    slot_dup  = first_col && !slot_col2;
    if (nr == 8'hFF)          ar = '0;
    else if (nr >= 8'(IMG_H)) ar = CW'(IMG_H - 1);
    else                      ar = nr[CW-1:0];
    ac = (nc >= 8'(IMG_W)) ? CW'(IMG_W - 1) : nc[CW-1:0];
`else
    slot_zero = (nr >= 8'(IMG_H)) || (nc >= 8'(IMG_W));
    slot_dup  = 1'b0;
    ar        = nr[CW-1:0];
    ac        = nc[CW-1:0];
`endif
    slot_addr = AW'(ar) * AW'(IMG_W) + AW'(ac);
  end

  // Issue the slot read and remember where its data lands next cycle.
  always_comb begin
    iaddr_d    = iaddr_q;
    cap_vld_d  = 1'b0;
    cap_row_d  = cap_row_q;
    cap_col2_d = cap_col2_q;
    cap_zero_d = cap_zero_q;
    cap_dup_d  = cap_dup_q;
    if (fetching) begin
      cap_vld_d  = 1'b1;
      cap_row_d  = slot_row;
      cap_col2_d = slot_col2;
      cap_zero_d = slot_zero;
      cap_dup_d  = slot_dup;
      if (!slot_zero) iaddr_d = slot_addr;
    end
  end

  // Frame sequencing: next state, slot counter and raster position.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        if (ready) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          slot_d  = '0;
        end
      end
      FETCH: begin
        if (last_slot) begin
          state_d = DRAIN;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (win_hs) begin
          if (frame_end) begin
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = FETCH;
            if (col_q == CW'(IMG_W - 1)) begin
              col_d = '0;
              row_d = row_q + CW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      slot_q     <= '0;
      iaddr_q    <= '0;
      cap_vld_q  <= 1'b0;
      cap_row_q  <= '0;
      cap_col2_q <= 1'b0;
      cap_zero_q <= 1'b0;
      cap_dup_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      slot_q     <= slot_d;
      iaddr_q    <= iaddr_d;
      cap_vld_q  <= cap_vld_d;
      cap_row_q  <= cap_row_d;
      cap_col2_q <= cap_col2_d;
      cap_zero_q <= cap_zero_d;
      cap_dup_q  <= cap_dup_d;
    end
  end

  // First fetch cycle of a window either starts a fresh row or slides the old one.
  assign win_clr = fetching && (slot_q == 3'd0) && first_col;
  assign win_shl = fetching && (slot_q == 3'd0) && !first_col;
  assign ld_dat  = cap_zero_q ? '0 : wf.idata;

  mfe_win_shift u_shift (
    .clk      (clk),
    .reset    (reset),
    .clr      (win_clr),
    .shl      (win_shl),
    .ld_vld   (cap_vld_q),
    .ld_col2  (cap_col2_q),
    .ld_dup   (cap_dup_q),
    .ld_row   (cap_row_q),
    .ld_dat   (ld_dat),
    .win_data (wf.win_data)
  );

  assign wf.iaddr     = iaddr_d;
  assign wf.win_valid = (state_q == OUT);
  assign wf.win_row   = row_q;
  assign wf.win_col   = col_q;
  assign busy         = (state_q == FETCH) || (state_q == DRAIN) || (state_q == OUT);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_mfe_window_fetch.sv
// Bench for the window fetcher: ROM model, random consumer stalls, per-cycle window compare.
// Latency: checks 7/4-cycle window latency and the single done pulse.
// Backpressure: holds win_ready low to confirm the window is frozen.
module tb_mfe_window_fetch;
  import mfe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ready;
  logic busy;
  logic done;

  mfe_window_fetch_if wf ();

  mfe_window_fetch dut (
    .clk   (clk),
    .reset (reset),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .wf    (wf)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:IMG_W*IMG_H-1];

  // Image ROM: one cycle read latency.
  always @(posedge clk) wf.idata <= mem[wf.iaddr];

  int checks   = 0;
  int failures = 0;
  bit abort    = 0;
  int hs_count = 0;
  int exp_r    = 0;
  int exp_c    = 0;
  bit prev_hs  = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference pixel at (r,c) with the border rule applied.
  function automatic logic [DW-1:0] pix(input int r, input int c);
    int rr, cc;
    rr = r;
    cc = c;
`ifdef MFE_WF_REPLICATE_EN
    if (rr < 0) rr = 0;
    if (rr > IMG_H - 1) rr = IMG_H - 1;
    if (cc < 0) cc = 0;
    if (cc > IMG_W - 1) cc = IMG_W - 1;
`else
    if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W) return '0;
`endif
    return mem[rr * IMG_W + cc];
  endfunction

  // Reference window: taps row-major, tap 0 in the top byte.
  function automatic logic [9*DW-1:0] win_exp(input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w[(8 - ((dr + 1) * 3 + (dc + 1))) * DW +: DW] = pix(r + dr, c + dc);
    return w;
  endfunction

  function automatic logic [DW-1:0] tap(input logic [9*DW-1:0] w, input int i);
    return w[(8 - i) * DW +: DW];
  endfunction

  // Per-cycle compare of the window channel against the raster-order model.
  always @(negedge clk) begin
    if (reset) begin
      exp_r    = 0;
      exp_c    = 0;
      prev_hs  = 0;
      hs_count = 0;
    end else begin
      if (prev_hs) chk("valid_after_accept", {79'b0, wf.win_valid}, 80'd0);
      if (wf.win_valid) begin
        chk("win_row", {73'b0, wf.win_row}, 80'(exp_r));
        chk("win_col", {73'b0, wf.win_col}, 80'(exp_c));
        chk("win_data", {8'b0, wf.win_data}, {8'b0, win_exp(exp_r, exp_c)});
      end
      prev_hs = wf.win_valid && wf.win_ready;
      if (prev_hs) begin
        hs_count++;
        if (exp_c == IMG_W - 1) begin
          exp_c = 0;
          exp_r = (exp_r == IMG_H - 1) ? 0 : exp_r + 1;
        end else begin
          exp_c++;
        end
      end
    end
  end

  // Called just after a rising edge; returns edges waited until win_valid.
  task automatic wait_valid(output int n);
    n = 0;
    if (abort) return;
    while (!wf.win_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_timeout", {79'b0, wf.win_valid}, 80'd1);
    if (!wf.win_valid) abort = 1;
  endtask

  task automatic take(input int stall);
    int n;
    wait_valid(n);
    if (abort) return;
    repeat (stall) begin @(posedge clk); #1; end
    wf.win_ready = 1'b1;
    @(posedge clk); #1;
    wf.win_ready = 1'b0;
  endtask

  task automatic start_frame();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  {79'b0, busy}, 80'd0);
    chk({tag, "_done"},  {79'b0, done}, 80'd0);
    chk({tag, "_valid"}, {79'b0, wf.win_valid}, 80'd0);
    chk({tag, "_data"},  {8'b0, wf.win_data}, 80'd0);
    chk({tag, "_row"},   {73'b0, wf.win_row}, 80'd0);
    chk({tag, "_col"},   {73'b0, wf.win_col}, 80'd0);
    chk({tag, "_iaddr"}, {66'b0, wf.iaddr}, 80'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9*DW-1:0] lit00;
    logic [9*DW-1:0] w;
    reset        = 1'b1;
    ready        = 1'b0;
    wf.win_ready = 1'b0;
    for (int a = 0; a < IMG_W * IMG_H; a++) mem[a] = DW'(a);
`ifdef MFE_WF_REPLICATE_EN
    lit00 = 72'h00_00_01_00_00_01_80_80_81;
`else
    lit00 = 72'h00_00_00_00_00_01_00_80_81;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_outputs("idle_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame A: start latency, window (0,0), backpressure at (2,3), reset at (3,3).
    chk("model_pin_00", {8'b0, win_exp(0, 0)}, {8'b0, lit00});
    start_frame();
    chk("busy_after_ready", {79'b0, busy}, 80'd1);
    chk("valid_early", {79'b0, wf.win_valid}, 80'd0);
    wait_valid(n);
    chk("lat_col0", 80'(n), 80'd7);
    chk("win00_data", {8'b0, wf.win_data}, {8'b0, lit00});
    chk("win00_row", {73'b0, wf.win_row}, 80'd0);
    chk("win00_col", {73'b0, wf.win_col}, 80'd0);
    for (int i = 0; i < 2 * IMG_W + 3 && !abort; i++) take($urandom_range(0, 2));
    wait_valid(n);
    chk("bp_row", {73'b0, wf.win_row}, 80'd2);
    chk("bp_col", {73'b0, wf.win_col}, 80'd3);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {79'b0, wf.win_valid}, 80'd1);
      chk("bp_iaddr", {66'b0, wf.iaddr}, 80'(3 * IMG_W + 4));
      chk("bp_data", {8'b0, wf.win_data}, {8'b0, win_exp(2, 3)});
      chk("bp_rowcol", {66'b0, wf.win_row, wf.win_col}, 80'({7'd2, 7'd3}));
    end
    ready = 1'b0;
    take(0);
    wait_valid(n);
    chk("after_bp_rowcol", {66'b0, wf.win_row, wf.win_col}, 80'({7'd2, 7'd4}));
    for (int i = 2 * IMG_W + 4; i < 3 * IMG_W + 3 && !abort; i++) take($urandom_range(0, 2));
    wait_valid(n);
    chk("pre_rst_rowcol", {66'b0, wf.win_row, wf.win_col}, 80'({7'd3, 7'd3}));
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame B: restart at (0,0) and interior window (5,10).
    start_frame();
    wait_valid(n);
    chk("restart_lat", 80'(n), 80'd7);
    chk("restart_data", {8'b0, wf.win_data}, {8'b0, lit00});
    for (int i = 0; i < 5 * IMG_W + 9 && !abort; i++) take($urandom_range(0, 2));
    take(0);
    wait_valid(n);
    chk("lat_col_gt0", 80'(n), 80'd4);
    w = win_exp(5, 10);
    chk("model_pin_510_p0", {72'b0, tap(w, P0)}, 80'h09);
    chk("model_pin_510_p4", {72'b0, tap(w, CENTER)}, 80'h8A);
    chk("win510_p0", {72'b0, tap(wf.win_data, P0)}, 80'h09);
    chk("win510_p4", {72'b0, tap(wf.win_data, CENTER)}, 80'h8A);
    chk("win510_p8", {72'b0, tap(wf.win_data, P8)}, 80'h0B);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame C: random image, full frame, done pulse and accept count.
    for (int a = 0; a < IMG_W * IMG_H; a++) mem[a] = DW'($urandom);
    start_frame();
    for (int i = 0; i < IMG_W * IMG_H - 1 && !abort; i++)
      take((i < 300) ? int'($urandom_range(0, 2)) : 0);
    wait_valid(n);
    chk("last_rowcol", {66'b0, wf.win_row, wf.win_col}, 80'({7'd127, 7'd127}));
`ifdef MFE_WF_REPLICATE_EN
    chk("last_p8", {72'b0, tap(wf.win_data, P8)}, {72'b0, mem[IMG_W * IMG_H - 1]});
`else
    chk("last_right_col", {56'b0, tap(wf.win_data, P2), tap(wf.win_data, P5), tap(wf.win_data, P8)}, 80'd0);
    chk("last_bottom_row", {64'b0, tap(wf.win_data, P6), tap(wf.win_data, P7)}, 80'd0);
`endif
    chk("done_before_last", {79'b0, done}, 80'd0);
    take(0);
    chk("done_pulse", {79'b0, done}, 80'd1);
    chk("busy_at_done", {79'b0, busy}, 80'd0);
    chk("valid_at_done", {79'b0, wf.win_valid}, 80'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {79'b0, done}, 80'd0);
    chk("busy_after_done", {79'b0, busy}, 80'd0);
    chk("handshakes", 80'(hs_count), 80'(IMG_W * IMG_H));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
